dff_rr_ctrl: RTL and testbench
==============================

# dff_rr_ctrl

Round-robin controller that shares one capture register (o_q) among N requesters. It arbitrates fairly, holds a one-hot grant for a fixed number of cycles, then samples the winner's data into the shared register. It reports the captured value and its source with a single-cycle valid pulse. It sits between requester blocks and downstream logic that consumes one registered sample at a time.

## Interface
- N, 4, number of requesters (2..16)
- DW, 8, data width per requester
- HOLD, 2, grant hold cycles before capture (>=1)
- SW, 2, source index width; must satisfy 2**SW >= N
- i_clk  input  1  clock, rising edge
- i_rstn  input  1  reset, asynchronous, active-low
- i_req  input  N  request per requester; level, held until grant completes
- i_data  input  N*DW  packed data; slice k = i_data[k*DW +: DW]
- o_gnt  output  N  one-hot grant, registered
- o_q  output  DW  shared capture register
- o_q_vld  output  1  one-cycle pulse: o_q newly captured
- o_q_src  output  SW  index of requester that produced o_q

## Operation
- Reset values: o_gnt=0, o_q=0, o_q_vld=0, o_q_src=0, state=IDLE, hold counter=0, pointer ptr=0 (requester 0 checked first).
- States:
  - IDLE: no grant.
  - GRANT: o_gnt one-hot, counter running.
  - DONE: o_q_vld=1, no grant.
- Arbitration happens in IDLE and DONE.
  - Winner w = first k with i_req[k]=1, scanning ptr, ptr+1, ..., wrapping modulo N.
  - If any request: next state GRANT, o_gnt <= 1<<w, counter <= 0, winner index latched.
  - Otherwise: next state IDLE.
- GRANT: counter increments each cycle. Winner data must be stable throughout.
- GRANT, final cycle (counter==HOLD-1) with i_req[w] still 1:
  - o_q <= i_data slice w, o_q_src <= w, o_q_vld <= 1.
  - o_gnt <= 0, ptr <= (w+1) mod N.
  - Next state DONE.
- Abort: i_req[w]=0 in any GRANT cycle.
  - o_gnt <= 0, ptr <= (w+1) mod N, next state IDLE.
  - o_q, o_q_src and o_q_vld are not updated (o_q_vld stays 0).
- Requests from non-winners during GRANT are ignored. They are considered at the next arbitration.
- o_q holds its last value indefinitely. o_q_vld is high only in DONE.
- An asynchronous reset in any state returns all registers to reset values immediately. A capture in progress is discarded.

## Timing
- Request at edge 0 from IDLE:
  - o_gnt high for edges 1..HOLD.
  - o_q/o_q_vld/o_q_src valid after edge HOLD+1.
- Back-to-back transfers: arbitration in DONE puts the next grant at the edge after DONE. Throughput is one capture per HOLD+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- o_gnt is never multi-hot. o_gnt and o_q_vld are never high in the same cycle.

## Structure
- Shared package/header holds:
  - state encodings (IDLE=2'd0, GRANT=2'd1, DONE=2'd2)
  - default parameter values
- One combinational sub-module, dff_rr_pick:
  - inputs: req[N], ptr[SW]
  - outputs: any, idx[SW]
  - implementation: rotate, priority-encode, unrotate.
- Top level holds the FSM, hold counter, ptr, winner register and capture register.

## Test plan
All scenarios use N=4, DW=8, HOLD=2.
- Reset: assert i_rstn=0 mid-GRANT.
  - All outputs 0 immediately.
  - After release, req=4'b1000 -> o_gnt=4'b1000 at edges 1-2.
- Single request: req=4'b0100, data slice2=8'hA5 from IDLE.
  - o_gnt=4'b0100 at edges 1-2.
  - Edge 3: o_q=8'hA5, o_q_src=2, o_q_vld=1 for one cycle.
- Fairness: req=4'b1111 held with slices 8'h10/8'h11/8'h12/8'h13.
  - o_q_src sequence 0,1,2,3,0.
  - o_q_vld pulses every 3 cycles.
- Abort: req[1] dropped during its first grant cycle.
  - o_gnt=0 next edge, no o_q_vld, o_q unchanged.
  - Next winner checked from index 2.
- Wrap-around: after a capture from src=3, req=4'b0011 -> grant goes to 0, then 1.
- Late request: req[0] raised while req[2] is granted -> not granted until the DONE cycle of 2; granted at the edge after DONE.

Source files
------------

// File: rtl/dff_rr_ctrl_pkg.sv
// Shared definitions for the round-robin capture controller:
// FSM state encodings and default parameter values.
package dff_rr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int N_DEF    = 4;
    localparam int DW_DEF   = 8;
    localparam int HOLD_DEF = 2;
    localparam int SW_DEF   = 2;

endpackage

// File: rtl/dff_rr_pick.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, find the lowest set
// bit, then rotate the offset back into a requester index.
module dff_rr_pick
    import dff_rr_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = SW_DEF
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic          any_o,
    output logic [SW-1:0] idx_o
);

    logic [N-1:0] rot;
    int           off;

    always_comb begin
        rot   = '0;
        off   = 0;
        any_o = |req_i;
        for (int i = 0; i < N; i++) begin
            rot[i] = req_i[(int'(ptr_i) + i) % N];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        idx_o = SW'((int'(ptr_i) + off) % N);
    end

endmodule

// File: rtl/dff_rr_ctrl.sv
// Round-robin controller sharing one capture register among N requesters:
// grant for HOLD cycles, capture the winner's data, pulse valid for one cycle.
module dff_rr_ctrl
    import dff_rr_ctrl_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int HOLD = HOLD_DEF,
    parameter int SW   = SW_DEF
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [N-1:0]    i_req,
    input  logic [N*DW-1:0] i_data,
    output logic [N-1:0]    o_gnt,
    output logic [DW-1:0]   o_q,
    output logic            o_q_vld,
    output logic [SW-1:0]   o_q_src
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   win_q, win_d;
    logic [SW-1:0]   src_q, src_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [DW-1:0]   q_q, q_d;
    logic            vld_q, vld_d;
    logic            pick_any;
    logic [SW-1:0]   pick_idx;
    logic [SW-1:0]   win_nxt;

    dff_rr_pick #(.N(N), .SW(SW)) u_pick (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign win_nxt = SW'((int'(win_q) + 1) % N);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        src_d   = src_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_d   = '0;
                    win_d   = pick_idx;
                end
            end
            GRANT: begin
                // A dropped request abandons the slot but still advances the pointer.
                if (!i_req[win_q]) begin
                    gnt_d   = '0;
                    ptr_d   = win_nxt;
                    state_d = IDLE;
                end else if (cnt_q == CW'(HOLD - 1)) begin
                    q_d     = i_data[win_q*DW +: DW];
                    src_d   = win_q;
                    vld_d   = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = win_nxt;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            src_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            src_q   <= src_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            vld_q   <= vld_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_q     = q_q;
    assign o_q_vld = vld_q;
    assign o_q_src = src_q;

endmodule

// File: tb/tb_dff_rr_ctrl.sv
// Directed bench for dff_rr_ctrl (N=4, DW=8, HOLD=2) with a capture scoreboard.
module tb_dff_rr_ctrl;

    logic        i_clk;
    logic        i_rstn;
    logic [3:0]  i_req;
    logic [31:0] i_data;
    logic [3:0]  o_gnt;
    logic [7:0]  o_q;
    logic        o_q_vld;
    logic [1:0]  o_q_src;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    dff_rr_ctrl #(.N(4), .DW(8), .HOLD(2), .SW(2)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_req   (i_req),
        .i_data  (i_data),
        .o_gnt   (o_gnt),
        .o_q     (o_q),
        .o_q_vld (o_q_vld),
        .o_q_src (o_q_src)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [7:0] d);
        exp_t e;
        e.src = s;
        e.d   = d;
        sb.push_back(e);
    endtask

    // Capture checker and structural invariants, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            chk("gnt_onehot0", 32'($onehot0(o_gnt)), 32'd1);
            chk("gnt_vld_excl", 32'((|o_gnt) & o_q_vld), 32'd0);
            if (o_q_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_vld", 32'(o_q_vld), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_src", 32'(o_q_src), 32'(e.src));
                    chk("sb_data", 32'(o_q), 32'(e.d));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rstn = 1'b0;
        i_req  = '0;
        i_data = '0;
        #12;
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_q", 32'(o_q), 32'h0);
        chk("rst_vld", 32'(o_q_vld), 32'h0);
        chk("rst_src", 32'(o_q_src), 32'h0);
        i_rstn = 1'b1;

        // Fairness: all requesting, ptr starts at 0.
        i_data = pk(8'h10, 8'h11, 8'h12, 8'h13);
        i_req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push(2'(i % 4), 8'h10 + 8'(i % 4));
            tick();
            chk("fair_gnt1", 32'(o_gnt), 32'(4'b0001 << (i % 4)));
            chk("fair_vld0", 32'(o_q_vld), 32'd0);
            tick();
            chk("fair_gnt2", 32'(o_gnt), 32'(4'b0001 << (i % 4)));
            tick();
            chk("fair_gnt_off", 32'(o_gnt), 32'h0);
            chk("fair_vld1", 32'(o_q_vld), 32'd1);
        end
        i_req = '0;
        tick();
        chk("fair_idle_gnt", 32'(o_gnt), 32'h0);
        chk("fair_idle_vld", 32'(o_q_vld), 32'd0);

        // Abort: ptr=1, requester 1 drops during its first grant cycle.
        i_data = pk(8'h20, 8'h21, 8'h22, 8'h23);
        i_req  = 4'b0010;
        tick();
        chk("abort_gnt", 32'(o_gnt), 32'b0010);
        i_req = 4'b0000;
        tick();
        chk("abort_gnt_off", 32'(o_gnt), 32'h0);
        chk("abort_vld", 32'(o_q_vld), 32'd0);
        chk("abort_q", 32'(o_q), 32'h10);
        chk("abort_src", 32'(o_q_src), 32'd0);
        i_req = 4'b0011;
        push(2'd0, 8'h20);
        tick();
        chk("abort_next_gnt", 32'(o_gnt), 32'b0001);
        tick();
        tick();
        chk("abort_next_vld", 32'(o_q_vld), 32'd1);

        // Late request: req[0] raised while 2 is granted.
        i_data = pk(8'h30, 8'h31, 8'h32, 8'h33);
        i_req  = 4'b0100;
        push(2'd2, 8'h32);
        tick();
        chk("late_gnt2_a", 32'(o_gnt), 32'b0100);
        i_req = 4'b0101;
        tick();
        chk("late_gnt2_b", 32'(o_gnt), 32'b0100);
        tick();
        chk("late_done_gnt", 32'(o_gnt), 32'h0);
        chk("late_done_vld", 32'(o_q_vld), 32'd1);
        i_req = 4'b0001;
        push(2'd0, 8'h30);
        tick();
        chk("late_gnt0", 32'(o_gnt), 32'b0001);
        tick();
        tick();
        chk("late_vld0", 32'(o_q_vld), 32'd1);
        i_req = '0;
        tick();

        // Wrap-around: capture from 3, then 0011 -> 0 then 1.
        i_data = pk(8'h40, 8'h41, 8'h42, 8'h43);
        i_req  = 4'b1000;
        push(2'd3, 8'h43);
        tick();
        chk("wrap_gnt3", 32'(o_gnt), 32'b1000);
        tick();
        tick();
        chk("wrap_vld3", 32'(o_q_vld), 32'd1);
        i_req = 4'b0011;
        push(2'd0, 8'h40);
        push(2'd1, 8'h41);
        tick();
        chk("wrap_gnt0", 32'(o_gnt), 32'b0001);
        tick();
        tick();
        chk("wrap_vld0", 32'(o_q_vld), 32'd1);
        i_req = 4'b0010;
        tick();
        chk("wrap_gnt1", 32'(o_gnt), 32'b0010);
        tick();
        tick();
        chk("wrap_vld1", 32'(o_q_vld), 32'd1);
        i_req = '0;
        tick();

        // Reset asserted mid-grant discards the capture.
        i_req = 4'b0100;
        tick();
        chk("rstmid_gnt", 32'(o_gnt), 32'b0100);
        #2 i_rstn = 1'b0;
        #1;
        chk("rstmid_gnt0", 32'(o_gnt), 32'h0);
        chk("rstmid_q0", 32'(o_q), 32'h0);
        chk("rstmid_vld0", 32'(o_q_vld), 32'd0);
        chk("rstmid_src0", 32'(o_q_src), 32'd0);
        i_req  = 4'b1000;
        i_data = pk(8'h50, 8'h51, 8'h52, 8'h53);
        @(posedge i_clk);
        #3 i_rstn = 1'b1;
        push(2'd3, 8'h53);
        tick();
        chk("rstrel_gnt_a", 32'(o_gnt), 32'b1000);
        tick();
        chk("rstrel_gnt_b", 32'(o_gnt), 32'b1000);
        tick();
        chk("rstrel_vld", 32'(o_q_vld), 32'd1);
        i_req = '0;
        tick();

        // Single request from IDLE.
        i_data = pk(8'h00, 8'h00, 8'hA5, 8'h00);
        i_req  = 4'b0100;
        push(2'd2, 8'hA5);
        tick();
        chk("single_gnt_a", 32'(o_gnt), 32'b0100);
        tick();
        chk("single_gnt_b", 32'(o_gnt), 32'b0100);
        tick();
        chk("single_gnt_off", 32'(o_gnt), 32'h0);
        chk("single_vld", 32'(o_q_vld), 32'd1);
        chk("single_q", 32'(o_q), 32'hA5);
        i_req = '0;
        tick();
        chk("single_vld_pulse", 32'(o_q_vld), 32'd0);
        chk("single_q_hold", 32'(o_q), 32'hA5);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
